// File: rtl/aes_host_seq.sv
// Byte-serial host sequencer for the 8-bit aestop AES core.
// Define AES_SEQ_KEEPKEY_EN to keep the key loaded across blocks.
module aes_host_seq #(
  parameter int CORE_LAT  = 13,
  parameter int KEY_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_vld,
  input  logic [127:0] key_in,
  output logic         key_rdy,
  input  logic         blk_vld,
  input  logic [127:0] blk_in,
  input  logic         blk_mode,
  output logic         blk_rdy,
  output logic         res_vld,
  output logic [127:0] res_data,
  input  logic         res_rdy,
  output logic         key_loaded,
  output logic [7:0]   core_din,
  output logic         core_loadkey,
  output logic         core_load_shift,
  output logic         core_staenc,
  output logic         core_stadec,
  input  logic [7:0]   core_dout
);

  localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LW-1:0] LAT_END = LW'(CORE_LAT - 1);
  localparam logic [3:0]    LAST    = 4'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, LDKEY, LDBLK, START, WAIT, SHOUT, HOLD
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [LW-1:0] r_lat;
  logic [127:0]  r_sh;
  logic [127:0]  r_res;
  logic          r_mode;
  logic          r_kl;
  logic [7:0]    r_din;
  logic          r_loadkey;
  logic          r_ldsh;
  logic          r_staenc;
  logic          r_stadec;
  logic          r_resvld;
  logic [7:0]    r_dout;
  logic          r_cap;
  logic [3:0]    r_widx;
  logic          w_idle;

  assign w_idle          = (r_state == IDLE);
  assign key_rdy         = w_idle & rst;
  assign blk_rdy         = w_idle & r_kl & ~key_vld;
  assign res_vld         = r_resvld;
  assign res_data        = r_res;
  assign key_loaded      = r_kl;
  assign core_din        = r_din;
  assign core_loadkey    = r_loadkey;
  assign core_load_shift = r_ldsh;
  assign core_staenc     = r_staenc;
  assign core_stadec     = r_stadec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_sh      <= '0;
      r_res     <= '0;
      r_mode    <= 1'b0;
      r_kl      <= 1'b0;
      r_din     <= '0;
      r_loadkey <= 1'b0;
      r_ldsh    <= 1'b0;
      r_staenc  <= 1'b0;
      r_stadec  <= 1'b0;
      r_resvld  <= 1'b0;
      r_dout    <= '0;
      r_cap     <= 1'b0;
      r_widx    <= '0;
    end else begin
      // core_dout is registered once, so byte k lands one cycle after SHOUT k
      r_dout <= core_dout;
      r_cap  <= (r_state == SHOUT);
      r_widx <= r_cnt;
      if (r_cap) begin
        r_res[{r_widx, 3'b000} +: 8] <= r_dout;
        if (r_widx == LAST) r_resvld <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (key_vld) begin
            r_state   <= LDKEY;
            r_sh      <= key_in;
            r_cnt     <= '0;
            r_kl      <= 1'b0;
            r_loadkey <= 1'b1;
            r_din     <= key_in[7:0];
          end else if (blk_vld && r_kl) begin
            r_state <= LDBLK;
            r_sh    <= blk_in;
            r_mode  <= blk_mode;
            r_cnt   <= '0;
            r_ldsh  <= 1'b1;
            r_din   <= blk_in[7:0];
          end
        end
        LDKEY: begin
          r_sh <= r_sh >> 8;
          if (r_cnt == LAST) begin
            r_state   <= IDLE;
            r_loadkey <= 1'b0;
            r_din     <= '0;
            r_kl      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_din <= r_sh[15:8];
          end
        end
        LDBLK: begin
          r_sh <= r_sh >> 8;
          if (r_cnt == LAST) begin
            r_state  <= START;
            r_ldsh   <= 1'b0;
            r_din    <= '0;
            r_staenc <= ~r_mode;
            r_stadec <= r_mode;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_din <= r_sh[15:8];
          end
        end
        START: begin
          r_state  <= WAIT;
          r_staenc <= 1'b0;
          r_stadec <= 1'b0;
          r_lat    <= '0;
        end
        WAIT: begin
          if (r_lat == LAT_END) begin
            r_state <= SHOUT;
            r_ldsh  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        SHOUT: begin
          if (r_cnt == LAST) begin
            r_state <= HOLD;
            r_ldsh  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (r_resvld && res_rdy) begin
            r_state  <= IDLE;
            r_resvld <= 1'b0;
`ifndef AES_SEQ_KEEPKEY_EN
            r_kl     <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_seq.sv
// Bench for aes_host_seq: timeline model of the host protocol plus
// a stand-in core that returns a chosen 16-byte answer during shift-out.
module tb_aes_host_seq;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_SEQ_KEEPKEY_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         key_vld, key_rdy, blk_vld, blk_mode, blk_rdy;
  logic [127:0] key_in, blk_in, res_data;
  logic         res_vld, res_rdy, key_loaded;
  logic [7:0]   core_din, core_dout;
  logic         core_loadkey, core_load_shift, core_staenc, core_stadec;

  always #5 clk = ~clk;

  aes_host_seq dut (
    .clk(clk), .rst(rst),
    .key_vld(key_vld), .key_in(key_in), .key_rdy(key_rdy),
    .blk_vld(blk_vld), .blk_in(blk_in), .blk_mode(blk_mode),
    .blk_rdy(blk_rdy),
    .res_vld(res_vld), .res_data(res_data), .res_rdy(res_rdy),
    .key_loaded(key_loaded), .core_din(core_din),
    .core_loadkey(core_loadkey), .core_load_shift(core_load_shift),
    .core_staenc(core_staenc), .core_stadec(core_stadec),
    .core_dout(core_dout)
  );

  int checks = 0;
  int errors = 0;

  // model: operation in progress and cycle index inside it
  typedef enum {M_IDLE, M_KEY, M_BLK} mop_t;
  mop_t         m_op;
  int           m_t;
  bit           m_kl, m_mode, m_rknown, m_kacc, m_bacc;
  logic [127:0] m_key, m_blk, m_core, m_res, nxt_core;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic mdl_reset();
    m_op = M_IDLE; m_t = 0; m_kl = 0; m_mode = 0;
    m_res = '0; m_rknown = 1; m_kacc = 0; m_bacc = 0;
  endtask

  // Timeline of a block from its accept edge: 0-15 load, 16 start,
  // 17-29 core latency, 30-45 shift-out, result valid from 47.
  task automatic compare();
    logic [7:0] e_din;
    bit bs;
    bs = (m_op == M_BLK);
    e_din = '0;
    if (m_op == M_KEY) e_din = m_key[8*m_t +: 8];
    else if (bs && m_t < 16) e_din = m_blk[8*m_t +: 8];
    chk("key_rdy", key_rdy, m_op == M_IDLE && rst);
    chk("blk_rdy", blk_rdy, m_op == M_IDLE && m_kl && !key_vld);
    chk("key_loaded", key_loaded, m_kl);
    chk("core_din", core_din, e_din);
    chk("core_loadkey", core_loadkey, m_op == M_KEY);
    chk("core_load_shift", core_load_shift,
        bs && (m_t < 16 || (m_t >= 30 && m_t < 46)));
    chk("core_staenc", core_staenc, bs && m_t == 16 && !m_mode);
    chk("core_stadec", core_stadec, bs && m_t == 16 && m_mode);
    chk("res_vld", res_vld, bs && m_t >= 47);
    if (m_rknown) chk("res_data", res_data, m_res);
  endtask

  task automatic mdl_edge();
    m_kacc = 0;
    m_bacc = 0;
    if (!rst) return;
    case (m_op)
      M_IDLE: begin
        if (key_vld) begin
          m_op = M_KEY; m_t = 0; m_key = key_in; m_kl = 0; m_kacc = 1;
        end else if (blk_vld && m_kl) begin
          m_op = M_BLK; m_t = 0; m_blk = blk_in; m_mode = blk_mode;
          m_core = nxt_core; m_bacc = 1;
        end
      end
      M_KEY: begin
        m_t++;
        if (m_t == 16) begin m_op = M_IDLE; m_kl = 1; end
      end
      M_BLK: begin
        if (m_t >= 47) begin
          if (res_rdy) begin
            m_op = M_IDLE;
            if (!KEEP) m_kl = 0;
          end
        end else begin
          m_t++;
          if (m_t == 32) m_rknown = 0;
          if (m_t == 47) begin m_rknown = 1; m_res = m_core; end
        end
      end
      default: m_op = M_IDLE;
    endcase
  endtask

  // called at a negedge with inputs already driven
  task automatic step();
    if (m_op == M_BLK && m_t >= 30 && m_t < 46)
      core_dout = m_core[8*(m_t-30) +: 8];
    else
      core_dout = 8'($urandom());
    #1;
    compare();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
  endtask

  task automatic send_key(input logic [127:0] k);
    int n;
    n = 0;
    key_vld = 1; key_in = k;
    do begin step(); n++; end while (!m_kacc && n < 200);
    key_vld = 0;
    chk("key_accept", m_kacc, 1'b1);
  endtask

  task automatic send_blk(input logic [127:0] b, input bit md,
                          input logic [127:0] ans);
    int n;
    n = 0;
    blk_vld = 1; blk_in = b; blk_mode = md; nxt_core = ans;
    do begin step(); n++; end while (!m_bacc && n < 200);
    blk_vld = 0;
    chk("blk_accept", m_bacc, 1'b1);
  endtask

  task automatic release_res();
    int n;
    n = 0;
    res_rdy = 1;
    do begin step(); n++; end while (m_op != M_IDLE && n < 100);
    res_rdy = 0;
    chk("release", m_op == M_IDLE, 1'b1);
  endtask

  initial begin
    int n, enc, dec, act;
    rst = 0; key_vld = 0; blk_vld = 0; blk_mode = 0; res_rdy = 0;
    key_in = '0; blk_in = '0; core_dout = '0; nxt_core = '0;
    mdl_reset();
    @(negedge clk);
    chk("rst_res_data", res_data, '0);
    chk("rst_ctrl", {key_rdy, blk_rdy, res_vld, key_loaded, core_din,
        core_loadkey, core_load_shift, core_staenc, core_stadec}, '0);
    rst = 1;
    step();

    // encrypt known answer
    send_key(KEY);
    chk("kat_key_byte0", core_din, 8'h3c);
    send_blk(PT, 1'b0, CT);
    chk("kat_blk_byte0", core_din, 8'h34);
    n = 0;
    while (!res_vld && n < 100) begin step(); n++; end
    chk("kat_latency", n, 47);
    chk("kat_enc_result", res_data, CT);

    // backpressure
    for (int i = 0; i < 20; i++) step();
    chk("bp_res_data", res_data, CT);
    chk("bp_rdys", {key_rdy, blk_rdy, res_vld}, 3'b001);
    res_rdy = 1;
    step();
    res_rdy = 0;
    chk("bp_release_idle", key_rdy, 1'b1);
    chk("bp_key_loaded", key_loaded, KEEP);

    // decrypt known answer
    send_key(KEY);
    send_blk(CT, 1'b1, PT);
    n = 0; enc = 0; dec = 0;
    while (!res_vld && n < 100) begin
      step(); n++;
      enc += int'(core_staenc);
      dec += int'(core_stadec);
    end
    chk("dec_pulses", {enc[7:0], dec[7:0]}, 16'h0001);
    chk("kat_dec_result", res_data, PT);
    release_res();

    // arbitration: key wins, block follows when the key load ends
    send_key(KEY);
    n = 0;
    while (m_op != M_IDLE && n < 50) begin step(); n++; end
    key_vld = 1; key_in = KEY;
    blk_vld = 1; blk_in = PT; blk_mode = 0; nxt_core = CT;
    step();
    key_vld = 0;
    chk("arb_key_first", {core_loadkey, core_load_shift}, 2'b10);
    n = 0;
    while (!m_bacc && n < 50) begin step(); n++; end
    blk_vld = 0;
    chk("arb_gap", n, 17);
    chk("arb_blk_byte0", {core_load_shift, core_din}, 9'h134);
    n = 0;
    while (!res_vld && n < 100) begin step(); n++; end
    chk("arb_result", res_data, CT);
    release_res();

    // reset during shift-out byte 7
    send_key(rnd128());
    send_blk(rnd128(), 1'b0, rnd128());
    n = 0;
    while (!(m_op == M_BLK && m_t == 37) && n < 100) begin step(); n++; end
    chk("rst_at_shout7", core_load_shift, 1'b1);
    #2 rst = 0;
    #1;
    chk("arst_res_data", res_data, '0);
    chk("arst_ctrl", {key_rdy, blk_rdy, res_vld, key_loaded, core_din,
        core_loadkey, core_load_shift, core_staenc, core_stadec}, '0);
    mdl_reset();
    @(negedge clk);
    step();
    rst = 1;

    // block without a key is held off
    blk_vld = 1; blk_in = PT; blk_mode = 0; nxt_core = CT;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      act += int'(blk_rdy | core_loadkey | core_load_shift |
                  core_staenc | core_stadec);
    end
    chk("nokey_activity", act, 0);
    key_vld = 1; key_in = KEY;
    n = 0;
    while (!m_bacc && n < 100) begin
      step(); n++;
      if (m_kacc) key_vld = 0;
    end
    blk_vld = 0;
    n = 0;
    while (!res_vld && n < 100) begin step(); n++; end
    chk("post_rst_result", res_data, CT);
    release_res();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!key_vld && !blk_vld && $urandom_range(0, 3) == 0) begin
        if (!m_kl || $urandom_range(0, 5) == 0) begin
          key_vld = 1; key_in = rnd128();
        end else begin
          blk_vld = 1; blk_in = rnd128();
          blk_mode = 1'($urandom_range(0, 1));
          nxt_core = rnd128();
          if ($urandom_range(0, 4) == 0) begin
            key_vld = 1; key_in = rnd128();
          end
        end
      end
      if (blk_vld && !key_vld && !m_kl && m_op == M_IDLE) begin
        key_vld = 1; key_in = rnd128();
      end
      res_rdy = ($urandom_range(0, 2) == 0);
      step();
      if (m_kacc) key_vld = 0;
      if (m_bacc) blk_vld = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
